// File: rtl/memory_bus_arbiter.sv
// Two-requester arbiter for the shared memory-map bus: data side has fixed priority,
// fetch is forced through after STARVE_LIMIT consecutive data grants while it waits.
module memory_bus_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        i_cmd_start,
    input  logic        i_cmd_write,
    output logic        i_cmd_ready,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] i_rdata,
    output logic        i_rdata_valid,

    input  logic        d_cmd_start,
    input  logic        d_cmd_write,
    output logic        d_cmd_ready,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_rdata_valid,

    output logic        mem_cmd_start,
    output logic        mem_cmd_write,
    input  logic        mem_cmd_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rdata_valid
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] starve_q, starve_d;

    logic forceI;
    logic grantI;
    logic grantD;
    logic accept;

    // Read data is broadcast; only the valid strobes identify the owner.
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        forceI = i_cmd_start && (starve_q == STARVE_MAX);
        grantI = forceI || (i_cmd_start && !d_cmd_start);
        grantD = !forceI && d_cmd_start;

        state_d       = state_q;
        starve_d      = starve_q;
        accept        = 1'b0;
        mem_cmd_start = 1'b0;
        mem_cmd_write = d_cmd_write;
        mem_addr      = d_addr;
        mem_wdata     = d_wdata;
        i_cmd_ready   = 1'b0;
        d_cmd_ready   = 1'b0;
        i_rdata_valid = 1'b0;
        d_rdata_valid = 1'b0;

        case (state_q)
            IDLE: begin
                if (grantI) begin
                    mem_cmd_start = 1'b1;
                    mem_cmd_write = i_cmd_write;
                    mem_addr      = i_addr;
                    mem_wdata     = i_wdata;
                    i_cmd_ready   = mem_cmd_ready;
                end else if (grantD) begin
                    mem_cmd_start = 1'b1;
                    i_cmd_ready   = 1'b0;
                    d_cmd_ready   = mem_cmd_ready;
                end
                accept = mem_cmd_start && mem_cmd_ready;

                if (accept && !mem_cmd_write) begin
                    state_d = grantI ? BUSY_I : BUSY_D;
                end

                // Count only data wins that actually made fetch wait.
                if (accept && grantI) begin
                    starve_d = '0;
                end else if (accept && grantD && i_cmd_start && (starve_q != STARVE_MAX)) begin
                    starve_d = starve_q + CW'(1);
                end
            end
            BUSY_I: begin
                if (mem_rdata_valid) begin
                    i_rdata_valid = 1'b1;
                    state_d       = IDLE;
                end
            end
            BUSY_D: begin
                if (mem_rdata_valid) begin
                    d_rdata_valid = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake outputs are quiet while in reset, whatever the stale state says.
        if (reset) begin
            mem_cmd_start = 1'b0;
            i_cmd_ready   = 1'b0;
            d_cmd_ready   = 1'b0;
            i_rdata_valid = 1'b0;
            d_rdata_valid = 1'b0;
        end
    end

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Scoreboard bench for memory_bus_arbiter: directed stimulus pushes expected grants and
// responses; a negedge monitor pops and compares whenever the DUT accepts or responds.
module tb_memory_bus_arbiter;

    localparam int STARVE_LIMIT = 2;

    logic        clk;
    logic        reset;
    logic        i_cmd_start, i_cmd_write, i_cmd_ready;
    logic [31:0] i_addr, i_wdata, i_rdata;
    logic        i_rdata_valid;
    logic        d_cmd_start, d_cmd_write, d_cmd_ready;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        d_rdata_valid;
    logic        mem_cmd_start, mem_cmd_write, mem_cmd_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_rdata_valid;

    logic [67:0] expQ[$];
    logic [67:0] monObs;
    int          errorCount = 0;
    int          checkCount = 0;

    memory_bus_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk            (clk),
        .reset          (reset),
        .i_cmd_start    (i_cmd_start),
        .i_cmd_write    (i_cmd_write),
        .i_cmd_ready    (i_cmd_ready),
        .i_addr         (i_addr),
        .i_wdata        (i_wdata),
        .i_rdata        (i_rdata),
        .i_rdata_valid  (i_rdata_valid),
        .d_cmd_start    (d_cmd_start),
        .d_cmd_write    (d_cmd_write),
        .d_cmd_ready    (d_cmd_ready),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .d_rdata        (d_rdata),
        .d_rdata_valid  (d_rdata_valid),
        .mem_cmd_start  (mem_cmd_start),
        .mem_cmd_write  (mem_cmd_write),
        .mem_cmd_ready  (mem_cmd_ready),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_rdata_valid(mem_rdata_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [67:0] actual, input logic [67:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic popCompare(input string name, input logic [67:0] obs);
        if (expQ.size() == 0) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL unexpected %s: got %h expected nothing", name, obs);
        end else begin
            checkOutput(name, obs, expQ.pop_front());
        end
    endtask

    // Grant record: {kind=0, i_ready, d_ready, write, addr, wdata}
    task automatic expectGrant(input logic isI, input logic write, input logic [31:0] addr,
                               input logic [31:0] wdata);
        expQ.push_back({1'b0, isI, ~isI, write, addr, wdata});
    endtask

    // Response record: {kind=1, i_valid, d_valid, 0, i_rdata, d_rdata}
    task automatic expectResp(input logic isI, input logic [31:0] data);
        expQ.push_back({1'b1, isI, ~isI, 1'b0, data, data});
    endtask

    task automatic applyStimulus(input logic iStart, input logic iWrite, input logic [31:0] iAddr,
                                 input logic [31:0] iWdata, input logic dStart, input logic dWrite,
                                 input logic [31:0] dAddr, input logic [31:0] dWdata);
        i_cmd_start = iStart;
        i_cmd_write = iWrite;
        i_addr      = iAddr;
        i_wdata     = iWdata;
        d_cmd_start = dStart;
        d_cmd_write = dWrite;
        d_addr      = dAddr;
        d_wdata     = dWdata;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted command and every response strobe is matched in order.
    always @(negedge clk) begin
        if (mem_cmd_start && mem_cmd_ready) begin
            monObs = {1'b0, i_cmd_ready, d_cmd_ready, mem_cmd_write, mem_addr, mem_wdata};
            popCompare("grant", monObs);
        end
        if (i_rdata_valid || d_rdata_valid) begin
            monObs = {1'b1, i_rdata_valid, d_rdata_valid, 1'b0, i_rdata, d_rdata};
            popCompare("response", monObs);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        string       order;
        int          iIdx;
        int          dIdx;
        logic [31:0] aI, aD, wI, wD;

        reset           = 1'b1;
        mem_cmd_ready   = 1'b1;
        mem_rdata_valid = 1'b0;
        mem_rdata       = 32'h0;
        applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b1, 1'b0, 32'h0000_0020, 32'h0);
        stepCycle();
        #1;
        checkOutput("reset mem_cmd_start", 68'(mem_cmd_start), 68'(0));
        checkOutput("reset i_cmd_ready", 68'(i_cmd_ready), 68'(0));
        checkOutput("reset d_cmd_ready", 68'(d_cmd_ready), 68'(0));
        stepCycle();

        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h1111_1111, 32'h0, 1'b0, 1'b0, 32'h0000_0ABC, 32'h0000_0DEF);
        #1;
        checkOutput("idle mem_cmd_start", 68'(mem_cmd_start), 68'(0));
        checkOutput("idle mem_addr from d", 68'(mem_addr), 68'(32'h0000_0ABC));
        stepCycle();

        // Fetch read, response two cycles after the grant
        applyStimulus(1'b1, 1'b0, 32'h0000_0100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        expectGrant(1'b1, 1'b0, 32'h0000_0100, 32'h0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        stepCycle();
        mem_rdata_valid = 1'b1;
        mem_rdata       = 32'hDEAD_BEEF;
        expectResp(1'b1, 32'hDEAD_BEEF);
        stepCycle();
        mem_rdata_valid = 1'b0;

        // Simultaneous fetch read and data write: data first, fetch next cycle
        applyStimulus(1'b1, 1'b0, 32'h0000_0200, 32'h0, 1'b1, 1'b1, 32'hFF00_0000, 32'h0000_0055);
        expectGrant(1'b0, 1'b1, 32'hFF00_0000, 32'h0000_0055);
        stepCycle();
        applyStimulus(1'b1, 1'b0, 32'h0000_0200, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        expectGrant(1'b1, 1'b0, 32'h0000_0200, 32'h0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        mem_rdata_valid = 1'b1;
        mem_rdata       = 32'h1234_5678;
        expectResp(1'b1, 32'h1234_5678);
        stepCycle();
        mem_rdata_valid = 1'b0;

        // Data read outstanding while fetch waits; no regrant in the response cycle
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0000_0300, 32'h0);
        expectGrant(1'b0, 1'b0, 32'h0000_0300, 32'h0);
        stepCycle();
        applyStimulus(1'b1, 1'b0, 32'h0000_0400, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int k = 0; k < 2; k++) begin
            #1;
            checkOutput("busy i_cmd_ready", 68'(i_cmd_ready), 68'(0));
            checkOutput("busy mem_cmd_start", 68'(mem_cmd_start), 68'(0));
            stepCycle();
        end
        mem_rdata_valid = 1'b1;
        mem_rdata       = 32'hCAFE_F00D;
        expectResp(1'b0, 32'hCAFE_F00D);
        #1;
        checkOutput("response-cycle i_cmd_ready", 68'(i_cmd_ready), 68'(0));
        stepCycle();
        mem_rdata_valid = 1'b0;
        expectGrant(1'b1, 1'b0, 32'h0000_0400, 32'h0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        mem_rdata_valid = 1'b1;
        mem_rdata       = 32'h0BAD_F00D;
        expectResp(1'b1, 32'h0BAD_F00D);
        stepCycle();
        mem_rdata_valid = 1'b0;

        // Controller stalls three cycles with a data write pending
        mem_cmd_ready = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0000_0500, 32'h0000_5555);
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput("stall d_cmd_ready", 68'(d_cmd_ready), 68'(0));
            checkOutput("stall mem_cmd_start", 68'(mem_cmd_start), 68'(1));
            stepCycle();
        end
        mem_cmd_ready = 1'b1;
        expectGrant(1'b0, 1'b1, 32'h0000_0500, 32'h0000_5555);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        stepCycle();

        // Continuous writes from both sides with STARVE_LIMIT=2
        order = "DDIDDIDDI";
        iIdx  = 0;
        dIdx  = 0;
        for (int k = 0; k < 9; k++) begin
            aI = 32'h0000_1000 + 32'(iIdx * 4);
            wI = 32'h0000_A000 + 32'(iIdx);
            aD = 32'h0000_2000 + 32'(dIdx * 4);
            wD = 32'h0000_B000 + 32'(dIdx);
            applyStimulus(1'b1, 1'b1, aI, wI, 1'b1, 1'b1, aD, wD);
            if (order[k] == "I") begin
                expectGrant(1'b1, 1'b1, aI, wI);
                iIdx++;
            end else begin
                expectGrant(1'b0, 1'b1, aD, wD);
                dIdx++;
            end
            stepCycle();
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        stepCycle();

        // Reset while a data read is outstanding; its late response is dropped
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0000_0600, 32'h0);
        expectGrant(1'b0, 1'b0, 32'h0000_0600, 32'h0);
        stepCycle();
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0000_0666, 32'h0);
        #1;
        checkOutput("in-reset mem_cmd_start", 68'(mem_cmd_start), 68'(0));
        checkOutput("in-reset d_cmd_ready", 68'(d_cmd_ready), 68'(0));
        stepCycle();
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        mem_rdata_valid = 1'b1;
        mem_rdata       = 32'h0000_0BAD;
        #1;
        checkOutput("stale d_rdata_valid", 68'(d_rdata_valid), 68'(0));
        checkOutput("stale i_rdata_valid", 68'(i_rdata_valid), 68'(0));
        stepCycle();
        mem_rdata_valid = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0000_0700, 32'h0);
        expectGrant(1'b0, 1'b0, 32'h0000_0700, 32'h0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        mem_rdata_valid = 1'b1;
        mem_rdata       = 32'h7777_7777;
        expectResp(1'b0, 32'h7777_7777);
        stepCycle();
        mem_rdata_valid = 1'b0;

        stepCycle();
        stepCycle();
        checkOutput("scoreboard drained", 68'(expQ.size()), 68'(0));
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
